// File: rtl/console_uart_tx.sv
// Console byte sink for FPGA builds: buffers console writes in a small FIFO and
// serialises them 8N1, LSB first, onto a UART TX line that idles high.
module console_uart_tx #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            tx,
  output logic            busy,
  output logic            fifo_full,
  output logic            overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            pop_s;
  logic            push_s;
  logic            bit_end_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            wdata_unused_s;

  assign bit_end_s      = (baud_q == BAUD_LAST);
  assign fifo_empty_s   = (count_q == CNT_ZERO);
  assign fifo_full_s    = (count_q == CNT_FULL);
  assign wdata_unused_s = ^console_wdata[XLEN-1:8];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a pop happens whenever a new frame is launched
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = S_START;
          pop_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s && (bit_idx_q == 3'd7)) begin
          state_d = S_STOP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (!fifo_empty_s) begin
            state_d = S_START;
            pop_s   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        pop_s   = 1'b0;
      end
    endcase
  end

  // FSM outputs: baud counter, bit index, shift register and next tx level
  always_comb begin
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (pop_s) begin
      baud_d    = BAUD_ZERO;
      bit_idx_d = 3'd0;
      shift_d   = mem_q[rptr_q];
    end else if (state_q == S_IDLE) begin
      baud_d = BAUD_ZERO;
    end else if (bit_end_s) begin
      baud_d = BAUD_ZERO;
      if (state_q == S_DATA) begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end else begin
        bit_idx_d = 3'd0;
      end
    end else begin
      baud_d = baud_q + BAUD_ONE;
    end

    // tx follows the state being entered so the line register lines up with it
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_STOP:  tx_d = 1'b1;
      S_IDLE:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q    <= BAUD_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // FIFO control: a full FIFO still accepts a byte when a pop frees a slot on the same edge
  always_comb begin
    push_s     = console_we && (!fifo_full_s || pop_s);
    overflow_d = overflow_q | (console_we & ~push_s);
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer, occupancy and sticky overflow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_q     <= PTR_ZERO;
      wptr_q     <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      overflow_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= console_wdata[7:0];
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty_s;
  assign fifo_full = fifo_full_s;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx with CLK_DIV=4, FIFO_DEPTH=4; tx is logged
// every cycle and whole frames are compared bit-for-bit against hand-built patterns.
module tb_console_uart_tx;

  localparam int XLEN    = 32;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int LOGLEN  = 4096;

  logic            clk;
  logic            reset;
  logic            console_we;
  logic [XLEN-1:0] console_wdata;
  logic            tx;
  logic            busy;
  logic            fifo_full;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc = 0;
  logic tx_log [LOGLEN];

  console_uart_tx #(
    .XLEN(XLEN),
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .console_we(console_we),
    .console_wdata(console_wdata),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry ncyc holds tx as it stands after the most recent rising edge
  always @(negedge clk) begin
    if (ncyc < LOGLEN) tx_log[ncyc] <= tx;
    ncyc <= ncyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] data);
    console_we    = 1'b1;
    console_wdata = data;
    step();
  endtask

  task automatic idle_in();
    console_we    = 1'b0;
    console_wdata = '0;
  endtask

  task automatic wait_log(input int upto);
    int guard;
    guard = 0;
    while (ncyc < upto && guard < 2000) begin
      step();
      guard++;
    end
  endtask

  // One 8N1 frame: 4 cycles low, 8 data bits LSB first, 4 cycles high
  task automatic check_frame(input string tag, input int s, input logic [7:0] b);
    logic [39:0] obs;
    logic [39:0] exp;
    wait_log(s + 40);
    check({tag, "_logged"}, 64'(ncyc >= s + 40), 64'd1);
    for (int c = 0; c < 40; c++) begin
      int k;
      k = c / CLK_DIV;
      if (k == 0)      exp[c] = 1'b0;
      else if (k == 9) exp[c] = 1'b1;
      else             exp[c] = b[k-1];
      obs[c] = (s + c < LOGLEN) ? tx_log[s + c] : 1'bx;
    end
    check(tag, 64'(obs), 64'(exp));
  endtask

  task automatic check_quiet(input string tag, input int s, input int len);
    logic all_high;
    wait_log(s + len);
    all_high = 1'b1;
    for (int c = 0; c < len; c++) begin
      if (s + c >= LOGLEN || tx_log[s + c] !== 1'b1) all_high = 1'b0;
    end
    check(tag, 64'(all_high), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int s;
    reset = 1'b1;
    idle_in();
    #2;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Single byte 0x41: fall one cycle after the write edge, 40-cycle frame
    push(32'h0000_0041);
    idle_in();
    check("t1_tx_before_pop", 64'(tx), 64'd1);
    check("t1_busy_queued", 64'(busy), 64'd1);
    step();
    check("t1_tx_fall", 64'(tx), 64'd0);
    s = ncyc;
    check_frame("t1_frame_41", s, 8'h41);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_ovf", 64'(overflow), 64'd0);

    // Back-to-back 0x55, 0xAA with no idle gap
    push(32'h0000_0055);
    s = ncyc + 1;
    push(32'h0000_00AA);
    idle_in();
    check_frame("t2_frame_55", s, 8'h55);
    check_frame("t2_frame_aa", s + 40, 8'hAA);
    check("t2_busy_done", 64'(busy), 64'd0);

    // Write-only upper bits are ignored
    push(32'hDEAD_BE7F);
    s = ncyc + 1;
    idle_in();
    check_frame("t6_frame_7f", s, 8'h7F);
    check("t6_busy_done", 64'(busy), 64'd0);

    // Six bytes into a depth-4 FIFO: 0x06 is dropped
    push(32'h0000_0001);
    s = ncyc + 1;
    push(32'h0000_0002);
    push(32'h0000_0003);
    push(32'h0000_0004);
    push(32'h0000_0005);
    check("t3_full", 64'(fifo_full), 64'd1);
    check("t3_ovf_before_drop", 64'(overflow), 64'd0);
    push(32'h0000_0006);
    idle_in();
    check("t3_ovf_after_drop", 64'(overflow), 64'd1);
    check("t3_full_kept", 64'(fifo_full), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_frame($sformatf("t3_frame_%0d", i + 1), s + 40 * i, 8'(i + 1));
    end
    check("t3_busy_done", 64'(busy), 64'd0);
    check_quiet("t3_no_sixth", s + 200, 40);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Push into a full FIFO on the STOP-to-START pop edge
    do_reset();
    check("t4_ovf_cleared", 64'(overflow), 64'd0);
    push(32'h0000_0011);
    s = ncyc + 1;
    push(32'h0000_0022);
    push(32'h0000_0033);
    push(32'h0000_0044);
    push(32'h0000_0055);
    idle_in();
    check("t4_full", 64'(fifo_full), 64'd1);
    repeat (36) step();
    push(32'h0000_0077);
    idle_in();
    check("t4_ovf_on_pop_edge", 64'(overflow), 64'd0);
    check("t4_full_on_pop_edge", 64'(fifo_full), 64'd1);
    check_frame("t4_frame_11", s, 8'h11);
    check_frame("t4_frame_22", s + 40, 8'h22);
    check_frame("t4_frame_33", s + 80, 8'h33);
    check_frame("t4_frame_44", s + 120, 8'h44);
    check_frame("t4_frame_55", s + 160, 8'h55);
    check_frame("t4_frame_77", s + 200, 8'h77);
    check("t4_busy_done", 64'(busy), 64'd0);
    check("t4_ovf_final", 64'(overflow), 64'd0);

    // Asynchronous reset mid-DATA of 0x3C with two bytes queued
    push(32'h0000_003C);
    push(32'h0000_0001);
    push(32'h0000_0002);
    idle_in();
    repeat (4) step();
    check("t5_tx_bit0_low", 64'(tx), 64'd0);
    check("t5_busy_pre", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_tx", 64'(tx), 64'd1);
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_full", 64'(fifo_full), 64'd0);
    check("t5_async_ovf", 64'(overflow), 64'd0);
    step();
    #2;
    reset = 1'b0;
    step();
    s = ncyc;
    check_quiet("t5_no_frames", s, 100);
    check("t5_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
